// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle.
// Valid/ready on both sides; bypass passes the state through for the final round.
module mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         inv,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // A step of 4 wraps to 0 in two bits, so the counter simply stays at 0.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic         inv_q, inv_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  m0 [4];
        logic [7:0]  m1 [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m3 [4];
        logic [31:0] res;
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = col[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            // m0..m3 are the rotation coefficients applied to a_i .. a_(i+3)
            if (inv_mode) begin
                m0[r] = x8[r] ^ x4[r] ^ x2[r];
                m1[r] = x8[r] ^ x2[r] ^ a[r];
                m2[r] = x8[r] ^ x4[r] ^ a[r];
                m3[r] = x8[r] ^ a[r];
            end else begin
                m0[r] = x2[r];
                m1[r] = x2[r] ^ a[r];
                m2[r] = a[r];
                m3[r] = a[r];
            end
        end
        for (int unsigned r = 0; r < 4; r++) begin
            res[31 - 8*r -: 8] = m0[r] ^ m1[(r + 1) % 4] ^ m2[(r + 2) % 4] ^ m3[(r + 3) % 4];
        end
        return res;
    endfunction

    // Column c sits at bits [127-32c -: 32], i.e. slot (3-c) counting from the LSB.
    function automatic logic [127:0] apply_col(input logic [127:0] d, input logic [1:0] c,
                                               input logic inv_mode);
        logic [1:0]   slot;
        logic [127:0] r;
        slot = 2'd3 - c;
        r = d;
        r[32*slot +: 32] = mix_col(d[32*slot +: 32], inv_mode);
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_state;
                    inv_d   = inv;
                    cnt_d   = '0;
                    state_d = bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    data_d = apply_col(data_d, cnt_q + 2'(k), inv_q);
                end
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_state = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) driven in lockstep,
// checked every cycle against a transaction-level model plus hand-computed AES vectors.
module tb_mix_columns_seq;

    localparam int LAT  [3] = '{4, 2, 1};
    localparam int COLS [3] = '{1, 2, 4};

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V_C6    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         inv = 1'b0;
    logic         bypass = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [127:0] out_state [3];

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_state(in_state), .inv(inv), .bypass(bypass), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_state(out_state[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_state(in_state), .inv(inv), .bypass(bypass), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_state(out_state[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_state(in_state), .inv(inv), .bypass(bypass), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_state(out_state[2]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cols=%0d got=%h exp=%h", nm, COLS[i], got, exp);
    endtask

    // GF(2^8) product by shift-and-add over the bits of b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int k = 0; k < 4; k++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gmul(coef[j], a[(k + j) % 4]);
                r[127 - 8*(4*c + k) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Transaction model: 0 = waiting for input, 1 = computing, 2 = result held.
    int           m_mode [3] = '{0, 0, 0};
    int           m_left [3] = '{0, 0, 0};
    logic [127:0] m_out  [3] = '{'0, '0, '0};
    bit           m_zero [3] = '{1, 1, 1};

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_mode[i] <= 0;
                m_out[i]  <= '0;
                m_zero[i] <= 1'b1;
            end else if (m_mode[i] == 0) begin
                if (in_valid) begin
                    m_zero[i] <= 1'b0;
                    m_out[i]  <= bypass ? in_state : mix_state(in_state, inv);
                    m_mode[i] <= bypass ? 2 : 1;
                    m_left[i] <= LAT[i];
                end
            end else if (m_mode[i] == 1) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) m_mode[i] <= 2;
            end else if (out_ready) begin
                m_mode[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("in_ready", i, 128'(in_ready[i]), 128'(m_mode[i] == 0));
            chk("out_valid", i, 128'(out_valid[i]), 128'(m_mode[i] == 2));
            if (m_mode[i] == 2 || m_zero[i]) chk("out_state", i, out_state[i], m_out[i]);
        end
    end

    // One transaction with 14 cycles of back-pressure and junk input offered while busy.
    task automatic run_op(input logic [127:0] s, input bit iv, input bit byp,
                          input logic [127:0] expv, input string nm);
        int lat [3] = '{-1, -1, -1};
        @(negedge clk);
        in_state = s; inv = iv; bypass = byp; in_valid = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (lat[i] < 0 && out_valid[i]) lat[i] = n;
            if (n == 0) begin
                in_state = ~s; inv = ~iv; bypass = 1'b1;
            end
        end
        in_valid = 1'b0; bypass = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_latency"}, i, 128'(lat[i]), byp ? 128'(0) : 128'(LAT[i]));
            chk({nm, "_result"}, i, out_state[i], expv);
            chk({nm, "_held_in_ready"}, i, 128'(in_ready[i]), 128'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) chk({nm, "_handoff_in_ready"}, i, 128'(in_ready[i]), 128'(1));
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        in_state = V_PLAIN; inv = 1'b0; bypass = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", i, 128'(out_valid[i]), 128'(0));
            chk("rst_out_state", i, out_state[i], '0);
            chk("rst_in_ready", i, 128'(in_ready[i]), 128'(1));
        end
        #1 reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("model_fwd_vector", 0, mix_state(V_PLAIN, 1'b0), V_MIXED);
        chk("model_inv_vector", 0, mix_state(V_MIXED, 1'b1), V_PLAIN);
        chk("model_c6_vector", 0, mix_state(V_C6, 1'b0), V_C6);
        run_op(V_PLAIN, 1'b0, 1'b0, V_MIXED, "fwd");
        run_op(V_MIXED, 1'b1, 1'b0, V_PLAIN, "inv");
        run_op(V_BYP, 1'b0, 1'b1, V_BYP, "bypass");
        run_op(V_BYP, 1'b0, 1'b0, mix_state(V_BYP, 1'b0), "fwd2");
        run_op(mix_state(V_BYP, 1'b0), 1'b1, 1'b0, V_BYP, "roundtrip");
        reset_mid_busy();
        run_op(V_C6, 1'b0, 1'b0, V_C6, "after_reset");
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
